// File: rtl/pmem_responder.sv
// Physical-memory line responder: one held 128-bit read or write at a time, fixed-latency single-cycle pmem_resp.
// Optional read/write completion counters are built when PMEM_RESPONDER_STATS_EN is defined.
`timescale 1ns/1ps

module pmem_responder #(
    parameter int LATENCY     = 4,
    parameter int INDEX_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         busy,
    output logic         protocol_error,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
);

    localparam int         DEPTH      = 2 ** INDEX_WIDTH;
    localparam logic [7:0] LOAD_COUNT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_is_read;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [127:0]           r_wdata;
    logic [7:0]             r_count;
    logic [127:0]           r_rdata;
    logic                   r_protocol_error;
    logic [127:0]           r_mem [DEPTH];

    logic [INDEX_WIDTH-1:0] w_addr_index;
    logic                   w_accept;
    logic                   w_both;
    logic                   w_held;
    logic                   w_violation;
    logic                   w_enter_resp;
    logic                   w_resp_is_read;
    logic [INDEX_WIDTH-1:0] w_resp_index;
    logic                   w_unused_addr;

    assign w_addr_index  = pmem_address[4 +: INDEX_WIDTH];
    assign w_unused_addr = ^pmem_address;

    assign w_accept    = (r_state == IDLE) && (pmem_read != pmem_write);
    assign w_both      = (r_state == IDLE) && pmem_read && pmem_write;
    assign w_held      = r_is_read ? pmem_read : pmem_write;
    assign w_violation = (r_state == BUSY) && (r_is_read ? pmem_write : pmem_read);

    // The counter is loaded with LATENCY-1 and RESP is entered on the decrement that reaches zero.
    always_comb begin
        w_next_state = r_state;
        pmem_resp    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (!w_held) begin
                    w_next_state = IDLE;
                end else if (r_count == 8'd1) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                busy         = 1'b1;
                pmem_resp    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_read <= 1'b0;
            r_index   <= '0;
            r_wdata   <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_is_read <= pmem_read;
            r_index   <= w_addr_index;
            r_wdata   <= pmem_wdata;
            r_count   <= LOAD_COUNT;
        end else if ((r_state == BUSY) && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    // With LATENCY=1 RESP follows IDLE directly, so the read uses the live request rather than the latch.
    assign w_enter_resp   = (w_next_state == RESP);
    assign w_resp_is_read = (r_state == IDLE) ? pmem_read : r_is_read;
    assign w_resp_index   = (r_state == IDLE) ? w_addr_index : r_index;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (w_enter_resp && w_resp_is_read) begin
            r_rdata <= r_mem[w_resp_index];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_protocol_error <= 1'b0;
        end else if (w_both || w_violation) begin
            r_protocol_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == RESP) && !r_is_read) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    assign pmem_rdata     = r_rdata;
    assign protocol_error = r_protocol_error;

`ifdef PMEM_RESPONDER_STATS_EN
    logic [15:0] r_read_count;
    logic [15:0] r_write_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_read_count  <= '0;
            r_write_count <= '0;
        end else if (r_state == RESP) begin
            if (r_is_read && (r_read_count != 16'hFFFF)) begin
                r_read_count <= r_read_count + 16'd1;
            end
            if (!r_is_read && (r_write_count != 16'hFFFF)) begin
                r_write_count <= r_write_count + 16'd1;
            end
        end
    end

    assign read_count  = r_read_count;
    assign write_count = r_write_count;
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: vector table, multi-cycle corner sequences, then random traffic vs a line-array model.
`timescale 1ns/1ps

module tb_pmem_responder;

    localparam int LAT = 4;
    localparam int IW  = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [15:0]  pmem_address = '0;
    logic [127:0] pmem_wdata = '0;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         busy;
    logic         protocol_error;
    logic [15:0]  read_count;
    logic [15:0]  write_count;

    always #5 clk = ~clk;

    pmem_responder #(
        .LATENCY     (LAT),
        .INDEX_WIDTH (IW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata),
        .busy           (busy),
        .protocol_error (protocol_error),
        .read_count     (read_count),
        .write_count    (write_count)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [127:0] modelMem [256];
    bit           modelValid [256];
    logic [127:0] modelLast;
    int           modelReads;
    int           modelWrites;
    logic [127:0] seenRdata;

    typedef struct {
        bit           isRead;
        logic [15:0]  addr;
        logic [127:0] data;
        logic [127:0] expRdata;
        string        name;
    } vec_t;

    vec_t vecs [11];

    localparam logic [127:0] LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LINE_B = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] LINE_C = 128'hCAFE_F00D_1357_9BDF_0246_8ACE_ABCD_EF01;
    localparam logic [127:0] LINE_D = 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_1234_5678;
    localparam logic [127:0] LINE_E = 128'h0000_0000_0000_0001_8000_0000_0000_0000;
    localparam logic [127:0] LINE_G = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr, input logic [127:0] data);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = data;
    endtask

    function automatic logic [127:0] expCount(input int n);
`ifdef PMEM_RESPONDER_STATS_EN
        return 128'(n);
`else
        return 128'(n * 0);
`endif
    endfunction

    // Waits (bounded) for the response of a request whose first cycle was 'elapsed' cycles ago, then updates the model.
    task automatic awaitResp(input string name, input bit isRead, input logic [15:0] addr,
                             input logic [127:0] data, input int elapsed);
        int cycles = elapsed;
        bit got = 1'b0;
        int idx = int'(addr[11:4]);
        while (!got && cycles < 4 * LAT + 8) begin
            @(posedge clk);
            #1;
            cycles++;
            if (pmem_resp) got = 1'b1;
        end
        checkOutput({name, "_resp"}, 128'(pmem_resp), 128'd1);
        if (got) begin
            checkOutput({name, "_latency"}, 128'(cycles), 128'(LAT));
            seenRdata = pmem_rdata;
            if (isRead) begin
                modelLast = modelMem[idx];
                modelReads++;
            end else begin
                modelMem[idx]   = data;
                modelValid[idx] = 1'b1;
                modelWrites++;
            end
            checkOutput({name, "_rdata"}, pmem_rdata, modelLast);
        end
    endtask

    task automatic transact(input string name, input bit isRead, input logic [15:0] addr, input logic [127:0] data);
        applyStimulus(isRead, !isRead, addr, data);
        awaitResp(name, isRead, addr, data, 0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, addr, data);
        checkOutput({name, "_single_pulse"}, 128'(pmem_resp), 128'd0);
    endtask

    task automatic doReset(input string name);
        reset_n = 1'b0;
        #1;
        checkOutput({name, "_resp"}, 128'(pmem_resp), 128'd0);
        checkOutput({name, "_rdata"}, pmem_rdata, 128'd0);
        checkOutput({name, "_busy"}, 128'(busy), 128'd0);
        checkOutput({name, "_perr"}, 128'(protocol_error), 128'd0);
        checkOutput({name, "_rcount"}, 128'(read_count), 128'd0);
        checkOutput({name, "_wcount"}, 128'(write_count), 128'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n     = 1'b1;
        modelLast   = '0;
        modelReads  = 0;
        modelWrites = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            modelMem[i]   = '0;
            modelValid[i] = 1'b0;
        end
        modelLast   = '0;
        modelReads  = 0;
        modelWrites = 0;
        seenRdata   = '0;

        vecs[0]  = '{1'b0, 16'h0040, LINE_A, 128'h0,  "wr_0040"};
        vecs[1]  = '{1'b1, 16'h004C, 128'h0, LINE_A, "rd_004C"};
        vecs[2]  = '{1'b0, 16'h1010, LINE_B, 128'h0,  "wr_1010"};
        vecs[3]  = '{1'b1, 16'h0010, 128'h0, LINE_B, "rd_0010_alias"};
        vecs[4]  = '{1'b0, 16'h0020, LINE_C, 128'h0,  "wr_0020"};
        vecs[5]  = '{1'b1, 16'hF02F, 128'h0, LINE_C, "rd_F02F_alias"};
        vecs[6]  = '{1'b0, 16'h0100, LINE_D, 128'h0,  "wr_0100"};
        vecs[7]  = '{1'b0, 16'h0200, LINE_E, 128'h0,  "wr_0200"};
        vecs[8]  = '{1'b1, 16'h0105, 128'h0, LINE_D, "rd_0105"};
        vecs[9]  = '{1'b0, 16'h004F, LINE_G, 128'h0,  "wr_004F"};
        vecs[10] = '{1'b1, 16'h8040, 128'h0, LINE_G, "rd_8040_alias"};

        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        doReset("reset_init");

        for (int v = 0; v < 11; v++) begin
            transact(vecs[v].name, vecs[v].isRead, vecs[v].addr, vecs[v].data);
            if (vecs[v].isRead) checkOutput({vecs[v].name, "_table"}, seenRdata, vecs[v].expRdata);
        end

        // Back-to-back reads: second request raised in the IDLE cycle right after the first response.
        applyStimulus(1'b1, 1'b0, 16'h0010, 128'h0);
        awaitResp("b2b_first", 1'b1, 16'h0010, 128'h0, 0);
        checkOutput("b2b_first_data", seenRdata, LINE_B);
        @(posedge clk);
        #1;
        checkOutput("b2b_gap_resp", 128'(pmem_resp), 128'd0);
        applyStimulus(1'b1, 1'b0, 16'h0020, 128'h0);
        awaitResp("b2b_second", 1'b1, 16'h0020, 128'h0, 0);
        checkOutput("b2b_second_data", seenRdata, LINE_C);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        checkOutput("b2b_no_dup", 128'(pmem_resp), 128'd0);

        // Abort: write dropped while BUSY must leave no response and no array update.
        applyStimulus(1'b0, 1'b1, 16'h0100, {128{1'b1}});
        @(posedge clk);
        #1;
        checkOutput("abort_busy", 128'(busy), 128'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 16'h0100, 128'h0);
        begin
            bit sawResp = 1'b0;
            for (int c = 0; c < 2 * LAT; c++) begin
                @(posedge clk);
                #1;
                if (pmem_resp) sawResp = 1'b1;
            end
            checkOutput("abort_no_resp", 128'(sawResp), 128'd0);
        end
        checkOutput("abort_idle", 128'(busy), 128'd0);
        transact("abort_readback", 1'b1, 16'h0100, 128'h0);
        checkOutput("abort_old_data", seenRdata, LINE_D);

        // Both request lines high in IDLE: flagged, nothing accepted.
        applyStimulus(1'b1, 1'b1, 16'h0300, 128'h0);
        @(posedge clk);
        #1;
        checkOutput("both_perr", 128'(protocol_error), 128'd1);
        checkOutput("both_busy", 128'(busy), 128'd0);
        checkOutput("both_resp", 128'(pmem_resp), 128'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        @(posedge clk);
        #1;
        checkOutput("both_sticky", 128'(protocol_error), 128'd1);
        doReset("reset_clr_perr");

        // Opposite line raised during a read's BUSY: read still completes, error set.
        applyStimulus(1'b1, 1'b0, 16'h0040, 128'h0);
        @(posedge clk);
        #1;
        pmem_write = 1'b1;
        @(posedge clk);
        #1;
        pmem_write = 1'b0;
        awaitResp("viol_read", 1'b1, 16'h0040, 128'h0, 2);
        checkOutput("viol_read_data", seenRdata, LINE_G);
        checkOutput("viol_perr", 128'(protocol_error), 128'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);

        // Reset in the second cycle of a write: outputs clear at once and the write is discarded.
        applyStimulus(1'b0, 1'b1, 16'h0200, {4{32'h0BAD_F00D}});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        doReset("reset_mid");
        transact("reset_mid_readback", 1'b1, 16'h0200, 128'h0);
        checkOutput("reset_mid_old_data", seenRdata, LINE_E);

        // Completion counters over 3 writes and 5 reads from a clean reset.
        doReset("reset_stats");
        transact("st_w0", 1'b0, 16'h0300, 128'h300);
        transact("st_w1", 1'b0, 16'h0310, 128'h310);
        transact("st_w2", 1'b0, 16'h0320, 128'h320);
        transact("st_r0", 1'b1, 16'h0300, 128'h0);
        transact("st_r1", 1'b1, 16'h0310, 128'h0);
        transact("st_r2", 1'b1, 16'h0320, 128'h0);
        transact("st_r3", 1'b1, 16'h0300, 128'h0);
        transact("st_r4", 1'b1, 16'h0040, 128'h0);
        checkOutput("stats_write_count", 128'(write_count), expCount(3));
        checkOutput("stats_read_count", 128'(read_count), expCount(5));

        // Random traffic against the line-array model; unknown lines are written before being read.
        for (int n = 0; n < 40; n++) begin
            int          idx = int'($urandom_range(0, 255));
            bit          rd  = ($urandom_range(0, 1) == 1) && modelValid[idx];
            logic [15:0] a   = {4'($urandom_range(0, 15)), 8'(idx), 4'($urandom_range(0, 15))};
            transact($sformatf("rand_%0d", n), rd, a, {$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("final_write_count", 128'(write_count), expCount(modelWrites));
        checkOutput("final_read_count", 128'(read_count), expCount(modelReads));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Synthesizable physical-memory responder: the far end of the pmem line interface driven by the L2 cache controller/datapath.
- Accepts one 128-bit line read or write at a time, held-request style.
- Returns a single-cycle pmem_resp after a fixed, parameterized latency.
- Backed by an internal line array; used as the main-memory model under the L2 in simulation and on FPGA.

Parameters:
- LATENCY, 4, cycles from request acceptance to pmem_resp (legal range 1..255)
- INDEX_WIDTH, 8, line-index bits taken from pmem_address[4 +: INDEX_WIDTH]; array depth 2**INDEX_WIDTH lines

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pmem_read  in  1  line read request, held high until pmem_resp
- pmem_write  in  1  line write request, held high until pmem_resp
- pmem_address  in  16  byte address; bits [3:0] ignored
- pmem_wdata  in  128  write line (pmem_bus)
- pmem_resp  out  1  one-cycle completion pulse
- pmem_rdata  out  128  read line (pmem_bus), valid in the pmem_resp cycle
- busy  out  1  high while a transaction is in flight
- protocol_error  out  1  sticky protocol-violation flag
- read_count  out  16  completed reads (see Optional Feature)
- write_count  out  16  completed writes (see Optional Feature)

Behaviour:
- Reset (async, reset_n low): state IDLE; pmem_resp=0, pmem_rdata=0, busy=0, protocol_error=0, counters=0. Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If exactly one of pmem_read/pmem_write is high at a clock edge: latch request type, line index and pmem_wdata; load latency counter with LATENCY-1; go to BUSY (or RESP if LATENCY=1).
  - If both are high: set protocol_error, stay IDLE, accept nothing.
- BUSY:
  - busy=1. Counter decrements each cycle; at 0 go to RESP.
  - Address and wdata changes on inputs are ignored (latched values used).
- RESP:
  - pmem_resp=1 for exactly this cycle.
  - Read: pmem_rdata = array[latched index], registered and held until the next read's RESP.
  - Write: array[latched index] <= latched wdata on the edge ending RESP; pmem_rdata unchanged.
  - RESP always returns to IDLE.
  - Timing: request first seen at edge t gives pmem_resp high in cycle t+LATENCY.
- Post-response turnaround:
  - The initiator drops its request the cycle after pmem_resp.
  - A request still high in the IDLE cycle after RESP is treated as a new transaction (back-to-back allowed).
  - Turnaround is one cycle minimum.
- Abort: accepted request line deasserted while in BUSY → return to IDLE next edge, no array write, no pmem_resp, no counter increment.
- Violation: opposite request line asserted while BUSY → set protocol_error; the transaction continues.
- protocol_error clears only on reset.
- Addressing: pmem_address bits above 4+INDEX_WIDTH are ignored, so addresses alias modulo 2**(INDEX_WIDTH+4) bytes.
- Reset mid-transaction: immediate return to IDLE, outputs to reset values, pending write discarded.

Optional Feature:
- Macro PMEM_RESPONDER_STATS_EN.
- Defined:
  - read_count / write_count increment on each RESP of the matching type.
  - Counters saturate at 16'hFFFF and are reset to 0.
- Undefined: read_count and write_count are tied to 0 and the counter logic is not built; all other behaviour is identical.

Test Plan:
- Write then read: write 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to 16'h0040, then read 16'h004C → pmem_resp 4 cycles after each request; rdata equals the written line (offset bits ignored).
- Back-to-back: read 16'h0010, then assert read of 16'h0020 in the cycle right after resp → second resp 4 cycles later; no lost or duplicate pulses.
- Abort: start write to 16'h0100 with data all-ones, drop pmem_write after 2 cycles, then read 16'h0100 → no resp for the write; read returns the prior contents.
- Violations: pmem_read and pmem_write both high in IDLE → protocol_error=1, busy=0, no resp. Separately, pmem_write raised during a read's BUSY → read completes normally and protocol_error=1.
- Reset mid-transaction: reset_n low in cycle 2 of a write to 16'h0200 → all outputs zero immediately; subsequent read of 16'h0200 returns the old data.
- Stats (PMEM_RESPONDER_STATS_EN defined): 3 writes and 5 reads → write_count=3, read_count=5. With the macro undefined, both counters stay 0.
